// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer for the iterative multiply/divide datapath.
//
// The controller walks IDLE -> LOAD -> RUN -> DONE. It issues load, step and
// clear strobes to the datapath registers, counts iterations, reports
// completion or divide-by-zero, and requests a pipeline stall while an
// operation is in flight.
//
// Parameters
//   STEPS      datapath iterations per operation (32 = radix-2, 16 = radix-4)
//   CNT_W      iteration counter width, 2**CNT_W > STEPS
//
// Ports
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-high reset
//   ctrl_mult  in   one-cycle start pulse, multiply (wins over ctrl_div)
//   ctrl_div   in   one-cycle start pulse, divide
//   flush      in   pipeline flush, aborts the in-flight operation
//   div_zero   in   datapath flag, divisor == 0, sampled in LOAD
//   dp_load    out  load operands into the datapath registers
//   dp_step    out  advance the datapath one iteration
//   dp_clr     out  synchronous clear of the datapath registers
//   dp_mode    out  0 = multiply, 1 = divide, latched at start
//   count      out  iterations completed in the current operation
//   busy       out  operation in flight (LOAD, RUN or DONE)
//   stall      out  pipeline stall request
//   ready      out  one-cycle pulse, result valid on the datapath output
//   exception  out  one-cycle pulse with ready on divide by zero
module multdiv_ctrl #(
    parameter int unsigned STEPS = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             flush,
    input  logic             div_zero,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_clr,
    output logic             dp_mode,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             stall,
    output logic             ready,
    output logic             exception
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Count value seen during the final RUN cycle, and the saturation value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STEPS);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count_nx;
    logic             mode_nx;
    logic             exc_nx;
    logic             start;
    logic             stall_q;

    assign start = ctrl_mult | ctrl_div;

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, counter and mode logic. Flush beats start, and start beats
    // the normal sequence, so a new start always restarts from LOAD.
    always_comb begin
        state_nx = state;
        count_nx = count;
        mode_nx  = dp_mode;
        exc_nx   = 1'b0;

        if (flush) begin
            state_nx = S_IDLE;
        end else if (start) begin
            state_nx = S_LOAD;
            count_nx = '0;
            mode_nx  = ~ctrl_mult;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_IDLE;
                end
                S_LOAD: begin
                    if (div_zero && dp_mode) begin
                        state_nx = S_DONE;
                        exc_nx   = 1'b1;
                    end else begin
                        state_nx = S_RUN;
                    end
                end
                S_RUN: begin
                    if (count < CNT_SAT) begin
                        count_nx = count + CNT_W'(1);
                    end
                    // Leave on the edge where count becomes STEPS.
                    if (count >= CNT_LAST) begin
                        state_nx = S_DONE;
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Output registers, decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count     <= '0;
            dp_mode   <= 1'b0;
            dp_load   <= 1'b0;
            dp_step   <= 1'b0;
            dp_clr    <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            exception <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            count     <= count_nx;
            dp_mode   <= mode_nx;
            dp_load   <= (state_nx == S_LOAD);
            dp_step   <= (state_nx == S_RUN);
            dp_clr    <= flush;
            busy      <= (state_nx != S_IDLE);
            ready     <= (state_nx == S_DONE);
            exception <= exc_nx;
            stall_q   <= (state_nx == S_LOAD) || (state_nx == S_RUN);
        end
    end

    // The start cycle itself must stall, before any register has seen it.
    assign stall = stall_q | ((state == S_IDLE) & start & ~flush & ~clr);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever ready is seen.
module tb_multdiv_ctrl;

    localparam int unsigned STEPS = 32;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             clr;
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             flush;
    logic             div_zero;
    logic             dp_load;
    logic             dp_step;
    logic             dp_clr;
    logic             dp_mode;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             stall;
    logic             ready;
    logic             exception;

    multdiv_ctrl #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clr       (clr),
        .ctrl_mult (ctrl_mult),
        .ctrl_div  (ctrl_div),
        .flush     (flush),
        .div_zero  (div_zero),
        .dp_load   (dp_load),
        .dp_step   (dp_step),
        .dp_clr    (dp_clr),
        .dp_mode   (dp_mode),
        .count     (count),
        .busy      (busy),
        .stall     (stall),
        .ready     (ready),
        .exception (exception)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   rcyc;
        logic exc;
        logic mode;
        int   cnt;
        int   steps;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   step_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts steps since the last load and checks every completion.
    always @(negedge clk) begin
        if (!clr) begin
            if (dp_load) step_cnt = 0;
            if (dp_step) step_cnt++;
            if (exception) check("exception_with_ready", longint'(ready), 1);
            if (ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ready_cycle", cyc, -1);
                end else begin
                    mon_e = sbq.pop_front();
                    check("ready_cycle", cyc, mon_e.rcyc);
                    check("exception", longint'(exception), longint'(mon_e.exc));
                    check("dp_mode", longint'(dp_mode), longint'(mon_e.mode));
                    check("count_done", longint'(count), mon_e.cnt);
                    check("step_cycles", step_cnt, mon_e.steps);
                    check("stall_in_done", longint'(stall), 0);
                    check("busy_in_done", longint'(busy), 1);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].rcyc) begin
                check("missing_ready", cyc, sbq[0].rcyc);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse a start for one cycle; optionally queue the expected completion.
    task automatic issue(input logic m, input logic d, input logic from_idle,
                         input logic push, input int lat, input logic exc,
                         input logic mode, input int cnt, input int steps);
        exp_t e;
        ctrl_mult = m;
        ctrl_div  = d;
        if (push) begin
            e.rcyc  = cyc + lat;
            e.exc   = exc;
            e.mode  = mode;
            e.cnt   = cnt;
            e.steps = steps;
            sbq.push_back(e);
        end
        if (from_idle) begin
            #1;
            check("stall_on_start", longint'(stall), 1);
        end
        @(posedge clk);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 200) begin
            tick(1);
            n++;
        end
        if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
        tick(2);
    endtask

    task automatic wait_count(input int target);
        int n = 0;
        while (int'(count) != target && n < 100) begin
            tick(1);
            n++;
        end
        check("reach_count", longint'(count), target);
    endtask

    task automatic check_all_zero(input string name);
        check(name, longint'({dp_load, dp_step, dp_clr, dp_mode, busy, stall, ready, exception}), 0);
        check({name, "_count"}, longint'(count), 0);
    endtask

    initial begin
        clr       = 1'b1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        flush     = 1'b0;
        div_zero  = 1'b0;
        #2;
        check_all_zero("reset_outputs");
        tick(2);
        clr = 1'b0;
        tick(1);

        // Multiply: load one cycle after start, steps follow, ready at +STEPS+2.
        issue(1'b1, 1'b0, 1'b1, 1'b1, STEPS + 2, 1'b0, 1'b0, STEPS, STEPS);
        check("mult_dp_load", longint'(dp_load), 1);
        check("mult_stall_load", longint'(stall), 1);
        tick(1);
        check("mult_dp_step", longint'(dp_step), 1);
        drain();

        // Divide with a non-zero divisor.
        issue(1'b0, 1'b1, 1'b1, 1'b1, STEPS + 2, 1'b0, 1'b1, STEPS, STEPS);
        drain();

        // Divide by zero: ready and exception two cycles after start.
        div_zero = 1'b1;
        issue(1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1, 0, 0);
        drain();
        div_zero = 1'b0;

        // Restart: multiply issued 15 cycles into a divide replaces it.
        issue(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        tick(14);
        check("restart_mode_before", longint'(dp_mode), 1);
        issue(1'b1, 1'b0, 1'b0, 1'b1, STEPS + 2, 1'b0, 1'b0, STEPS, STEPS);
        check("restart_dp_load", longint'(dp_load), 1);
        check("restart_mode_after", longint'(dp_mode), 0);
        drain();

        // Flush at count 20 together with a new start: back to IDLE, no load.
        issue(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        wait_count(20);
        flush     = 1'b1;
        ctrl_mult = 1'b1;
        tick(1);
        flush     = 1'b0;
        ctrl_mult = 1'b0;
        check("flush_dp_clr", longint'(dp_clr), 1);
        check("flush_busy", longint'(busy), 0);
        check("flush_no_load", longint'(dp_load), 0);
        check("flush_stall", longint'(stall), 0);
        tick(1);
        check("flush_dp_clr_once", longint'(dp_clr), 0);
        check("flush_no_load_later", longint'(dp_load), 0);
        tick(40);

        // Flush while idle only pulses dp_clr.
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("idle_flush_dp_clr", longint'(dp_clr), 1);
        check("idle_flush_busy", longint'(busy), 0);
        tick(1);
        check("idle_flush_dp_clr_once", longint'(dp_clr), 0);

        // Both starts: multiply wins, no exception even with div_zero set.
        div_zero = 1'b1;
        issue(1'b1, 1'b1, 1'b1, 1'b1, STEPS + 2, 1'b0, 1'b0, STEPS, STEPS);
        drain();
        div_zero = 1'b0;

        // Asynchronous reset mid-RUN at count 10.
        issue(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        wait_count(10);
        check("pre_reset_mode", longint'(dp_mode), 1);
        clr = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        tick(1);
        clr = 1'b0;
        tick(3);
        check("post_reset_busy", longint'(busy), 0);
        check("post_reset_queue", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
